// File: rtl/elbeth_branch_predictor_if.sv
// ---------------------------------------------------------------------------
// elbeth_branch_predictor_if
// Bundles the fetch-lookup, resolve/update, redirect and statistics signals
// of the ELBETH branch predictor.
//   master : pipeline side (drives if_pc, flush, upd_*; observes predictions)
//   slave  : predictor side (elbeth_branch_predictor)
// Parameters: ADDR_W (PC width), STAT_W (performance counter width).
//
// Update handshake: upd_valid is a one-cycle qualifier with no ready/back-
// pressure. When upd_valid is high, every upd_* field describes one resolved
// control-transfer instruction and is consumed on that rising edge; when low,
// the upd_* fields are ignored and mispredict is held low.
// ---------------------------------------------------------------------------
interface elbeth_branch_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 32
);
    // Fetch lookup
    logic [ADDR_W-1:0] if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    // Maintenance
    logic              flush;
    // Resolve / update
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_is_jump;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    // Redirect
    logic              mispredict;
    logic [ADDR_W-1:0] correct_pc;
    // Statistics
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output if_pc, flush, upd_valid, upd_pc, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_hit, pred_taken, pred_target, mispredict, correct_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, flush, upd_valid, upd_pc, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_hit, pred_taken, pred_target, mispredict, correct_pc,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/elbeth_branch_predictor.sv
// ---------------------------------------------------------------------------
// elbeth_branch_predictor
// Direct-mapped BTB with a 2-bit saturating counter per entry. The IF stage
// looks up if_pc combinationally; the ID-stage branch unit reports resolved
// outcomes, which train the table, raise mispredict/correct_pc and bump the
// saturating performance counters.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bp    - elbeth_branch_predictor_if.slave (lookup, update, redirect, stats)
// Parameters: ENTRIES (power of two, 2..256), ADDR_W, STAT_W.
// ---------------------------------------------------------------------------
module elbeth_branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int STAT_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    elbeth_branch_predictor_if.slave    bp
);
    localparam int INDEX_W = $clog2(ENTRIES);
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    // Counter encoding: 0 SNT, 1 WNT, 2 WT, 3 ST
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [STAT_W-1:0]  stat_br_q;
    logic [STAT_W-1:0]  stat_mp_q;

    // ---------------- Lookup (combinational) ----------------
    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic               lk_taken;

    assign lk_idx   = bp.if_pc[INDEX_W+1:2];
    assign lk_tag   = bp.if_pc[ADDR_W-1:INDEX_W+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];

    assign bp.pred_hit    = lk_hit;
    assign bp.pred_taken  = lk_taken;
    // PC+4 wraps naturally modulo 2^ADDR_W
    assign bp.pred_target = lk_taken ? target_q[lk_idx] : (bp.if_pc + ADDR_W'(4));

    // ---------------- Resolve / redirect ----------------
    logic mispredict;

    assign mispredict = bp.upd_valid &&
                        ((bp.upd_taken != bp.upd_pred_taken) ||
                         (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));

    assign bp.mispredict = mispredict;
    assign bp.correct_pc = bp.upd_taken ? bp.upd_target : (bp.upd_pc + ADDR_W'(4));

    // ---------------- Training decision ----------------
    logic [INDEX_W-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               upd_we;      // write valid/tag/counter of up_idx
    logic               upd_tgt_we;  // also write target
    logic [1:0]         upd_ctr_d;

    assign up_idx = bp.upd_pc[INDEX_W+1:2];
    assign up_tag = bp.upd_pc[ADDR_W-1:INDEX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        upd_we     = 1'b0;
        upd_tgt_we = 1'b0;
        upd_ctr_d  = ctr_q[up_idx];
        if (bp.upd_valid && !bp.flush) begin
            if (up_hit) begin
                upd_we = 1'b1;
                if (bp.upd_is_jump) begin
                    upd_ctr_d  = 2'd3;
                    upd_tgt_we = 1'b1;
                end else if (bp.upd_taken) begin
                    upd_ctr_d  = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
                    upd_tgt_we = 1'b1;
                end else begin
                    upd_ctr_d  = (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                // Allocate, evicting whatever occupies this index
                upd_we     = 1'b1;
                upd_tgt_we = 1'b1;
                upd_ctr_d  = bp.upd_is_jump ? 2'd3 : 2'd2;
            end
        end
    end

    // ---------------- BTB storage ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (bp.flush) begin
            // Flush wins over a same-edge update
            valid_q <= '0;
        end else if (upd_we) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            ctr_q[up_idx]   <= upd_ctr_d;
            if (upd_tgt_we) begin
                target_q[up_idx] <= bp.upd_target;
            end
        end
    end

    // ---------------- Performance counters (saturating, flush-immune) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (bp.upd_valid && (stat_br_q != '1)) begin
                stat_br_q <= stat_br_q + STAT_W'(1);
            end
            if (mispredict && (stat_mp_q != '1)) begin
                stat_mp_q <= stat_mp_q + STAT_W'(1);
            end
        end
    end

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mp_q;
endmodule

// File: tb/tb_elbeth_branch_predictor.sv
module tb_elbeth_branch_predictor;
    localparam int ADDR_W = 32;
    localparam int STAT_W = 4;
    localparam int NVEC   = 18;

    // ---------------- Clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    elbeth_branch_predictor_if #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) bp ();

    elbeth_branch_predictor #(
        .ENTRIES(16),
        .ADDR_W (ADDR_W),
        .STAT_W (STAT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bp   (bp)
    );

    // ---------------- Scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int exp_br = 0;
    int exp_mp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic count_edge(input logic v, input logic mp);
        if (v && exp_br < 15) exp_br++;
        if (mp && exp_mp < 15) exp_mp++;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, ".stat_branches"}, 32'(bp.stat_branches), 32'(exp_br));
        chk({tag, ".stat_mispredicts"}, 32'(bp.stat_mispredicts), 32'(exp_mp));
    endtask

    // ---------------- Driver ----------------
    task automatic drive_upd(input logic v, input logic fl, input logic [31:0] pc,
                             input logic j, input logic tk, input logic [31:0] tg,
                             input logic ptk, input logic [31:0] ptg);
        bp.upd_valid       = v;
        bp.flush           = fl;
        bp.upd_pc          = pc;
        bp.upd_is_jump     = j;
        bp.upd_taken       = tk;
        bp.upd_target      = tg;
        bp.upd_pred_taken  = ptk;
        bp.upd_pred_target = ptg;
    endtask

    task automatic idle_upd();
        bp.upd_valid = 1'b0;
        bp.flush     = 1'b0;
    endtask

    // ---------------- Vector table ----------------
    typedef struct {
        logic        v;
        logic        fl;
        logic [31:0] pc;
        logic        j;
        logic        tk;
        logic [31:0] tg;
        logic        ptk;
        logic [31:0] ptg;
        logic [31:0] lk;      // lookup PC after the edge
        logic        e_mp;
        logic [31:0] e_cpc;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic v, input logic fl, input logic [31:0] pc,
                                input logic j, input logic tk, input logic [31:0] tg,
                                input logic ptk, input logic [31:0] ptg, input logic [31:0] lk,
                                input logic e_mp, input logic [31:0] e_cpc,
                                input logic e_hit, input logic e_tk, input logic [31:0] e_tgt);
        vec_t r;
        r.v = v; r.fl = fl; r.pc = pc; r.j = j; r.tk = tk; r.tg = tg;
        r.ptk = ptk; r.ptg = ptg; r.lk = lk;
        r.e_mp = e_mp; r.e_cpc = e_cpc; r.e_hit = e_hit; r.e_tk = e_tk; r.e_tgt = e_tgt;
        return r;
    endfunction

    initial begin
        //              v  fl pc            j  tk tg            ptk ptg           lookup        mp cpc           hit tk tgt
        vecs[0]  = mk(1, 0, 32'h00001000, 0, 1, 32'h00000F00, 0, 32'h00001004, 32'h00001000, 1, 32'h00000F00, 1, 1, 32'h00000F00);
        vecs[1]  = mk(1, 0, 32'h00001000, 0, 0, 32'h00000F00, 1, 32'h00000F00, 32'h00001000, 1, 32'h00001004, 1, 0, 32'h00001004);
        vecs[2]  = mk(1, 0, 32'h00001000, 0, 0, 32'h00000F00, 0, 32'h00001004, 32'h00001000, 0, 32'h00001004, 1, 0, 32'h00001004);
        vecs[3]  = mk(1, 0, 32'h00001000, 0, 0, 32'h00000F00, 0, 32'h00001004, 32'h00001000, 0, 32'h00001004, 1, 0, 32'h00001004);
        vecs[4]  = mk(1, 0, 32'h00001000, 0, 1, 32'h00000F00, 0, 32'h00001004, 32'h00001000, 1, 32'h00000F00, 1, 0, 32'h00001004);
        vecs[5]  = mk(1, 0, 32'h00001000, 0, 1, 32'h00000F00, 0, 32'h00001004, 32'h00001000, 1, 32'h00000F00, 1, 1, 32'h00000F00);
        vecs[6]  = mk(1, 0, 32'hFFFF0000, 1, 1, 32'hFFFF00F2, 0, 32'hFFFF0004, 32'hFFFF0000, 1, 32'hFFFF00F2, 1, 1, 32'hFFFF00F2);
        vecs[7]  = mk(1, 0, 32'hFFFF0000, 1, 1, 32'hFFFF00F2, 1, 32'hFFFF00F2, 32'h00001000, 0, 32'hFFFF00F2, 0, 0, 32'h00001004);
        vecs[8]  = mk(1, 0, 32'h00001000, 0, 1, 32'h00000F00, 1, 32'h00000F00, 32'hFFFF0000, 0, 32'h00000F00, 0, 0, 32'hFFFF0004);
        vecs[9]  = mk(1, 0, 32'h00001000, 0, 0, 32'h00000F00, 1, 32'h00000F00, 32'h00001000, 1, 32'h00001004, 1, 0, 32'h00001004);
        vecs[10] = mk(1, 0, 32'h00001000, 1, 1, 32'h00002222, 0, 32'h00001004, 32'h00001000, 1, 32'h00002222, 1, 1, 32'h00002222);
        vecs[11] = mk(1, 0, 32'h00001000, 0, 0, 32'h00002222, 1, 32'h00002222, 32'h00001000, 1, 32'h00001004, 1, 1, 32'h00002222);
        vecs[12] = mk(1, 0, 32'h00001000, 0, 1, 32'h00003330, 1, 32'h00002222, 32'h00001000, 1, 32'h00003330, 1, 1, 32'h00003330);
        vecs[13] = mk(1, 0, 32'h00002000, 0, 1, 32'h00000500, 0, 32'h00002004, 32'h00001000, 1, 32'h00000500, 0, 0, 32'h00001004);
        vecs[14] = mk(1, 0, 32'h00001044, 0, 0, 32'h00000700, 0, 32'h00001048, 32'h00001044, 0, 32'h00001048, 0, 0, 32'h00001048);
        vecs[15] = mk(0, 0, 32'hFFFFFFFC, 0, 0, 32'h00000700, 1, 32'h00000000, 32'hFFFFFFFC, 0, 32'h00000000, 0, 0, 32'h00000000);
        vecs[16] = mk(1, 1, 32'h00001044, 0, 1, 32'h00000700, 0, 32'h00001048, 32'h00002000, 1, 32'h00000700, 0, 0, 32'h00002004);
        vecs[17] = mk(0, 0, 32'h00001044, 0, 0, 32'h00000700, 0, 32'h00001048, 32'h00001044, 0, 32'h00001048, 0, 0, 32'h00001048);
    end

    // ---------------- Test sequence ----------------
    initial begin
        rst_n     = 1'b0;
        bp.if_pc  = 32'h00001000;
        drive_upd(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        #1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.pred_hit", 32'(bp.pred_hit), 32'd0);
        chk("rst.pred_taken", 32'(bp.pred_taken), 32'd0);
        chk("rst.pred_target", bp.pred_target, 32'h00001004);
        chk("rst.mispredict", 32'(bp.mispredict), 32'd0);
        chk_stats("rst");
        rst_n = 1'b1;

        // Table-driven section
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive_upd(vecs[i].v, vecs[i].fl, vecs[i].pc, vecs[i].j, vecs[i].tk,
                      vecs[i].tg, vecs[i].ptk, vecs[i].ptg);
            #1;
            chk($sformatf("v%0d.mispredict", i), 32'(bp.mispredict), 32'(vecs[i].e_mp));
            chk($sformatf("v%0d.correct_pc", i), bp.correct_pc, vecs[i].e_cpc);
            @(posedge clk);
            count_edge(vecs[i].v, vecs[i].e_mp);
            #1;
            idle_upd();
            bp.if_pc = vecs[i].lk;
            #1;
            chk($sformatf("v%0d.pred_hit", i), 32'(bp.pred_hit), 32'(vecs[i].e_hit));
            chk($sformatf("v%0d.pred_taken", i), 32'(bp.pred_taken), 32'(vecs[i].e_tk));
            chk($sformatf("v%0d.pred_target", i), bp.pred_target, vecs[i].e_tgt);
            chk_stats($sformatf("v%0d", i));
        end

        // Same-cycle lookup and update to one index returns pre-update contents
        @(negedge clk);
        drive_upd(1, 0, 32'h00001000, 0, 1, 32'h00000F00, 0, 32'h00001004);
        bp.if_pc = 32'h00001000;
        #1;
        chk("same_cycle.pred_hit", 32'(bp.pred_hit), 32'd0);
        @(posedge clk);
        count_edge(1'b1, 1'b1);
        #1;
        idle_upd();
        #1;
        chk("trained.pred_hit", 32'(bp.pred_hit), 32'd1);
        chk("trained.pred_target", bp.pred_target, 32'h00000F00);

        // Asynchronous reset in the middle of an update cycle
        @(negedge clk);
        drive_upd(1, 0, 32'h00001000, 0, 1, 32'h00000F00, 0, 32'h00001004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.pred_hit", 32'(bp.pred_hit), 32'd0);
        chk("midrst.pred_target", bp.pred_target, 32'h00001004);
        exp_br = 0;
        exp_mp = 0;
        chk_stats("midrst");
        idle_upd();
        #1;
        chk("midrst.mispredict", 32'(bp.mispredict), 32'd0);
        @(posedge clk);
        #1;
        chk("inrst.pred_hit", 32'(bp.pred_hit), 32'd0);
        chk_stats("inrst");

        // First edge after release performs a normal update
        @(negedge clk);
        rst_n = 1'b1;
        drive_upd(1, 0, 32'h00001044, 1, 1, 32'h00000044, 0, 32'h00001048);
        @(posedge clk);
        count_edge(1'b1, 1'b1);
        #1;
        idle_upd();
        bp.if_pc = 32'h00001044;
        #1;
        chk("post_rst.pred_hit", 32'(bp.pred_hit), 32'd1);
        chk("post_rst.pred_taken", 32'(bp.pred_taken), 32'd1);
        chk("post_rst.pred_target", bp.pred_target, 32'h00000044);
        chk_stats("post_rst");

        // Counter saturation: 20 mispredicting updates
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive_upd(1, 0, 32'h00001000, 0, 1, 32'h00000100, 0, 32'h00001004);
            #1;
            chk($sformatf("sat%0d.mispredict", k), 32'(bp.mispredict), 32'd1);
            @(posedge clk);
            count_edge(1'b1, 1'b1);
        end
        #1;
        idle_upd();
        #1;
        chk("sat.stat_branches", 32'(bp.stat_branches), 32'd15);
        chk("sat.stat_mispredicts", 32'(bp.stat_mispredicts), 32'd15);
        chk_stats("sat");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
